// File: rtl/mem_pkg.sv
// Shared helpers for the SRAM responder: address-split widths, stall counter
// sizing and the native-width response tuple.
package mem_pkg;

  localparam int DefaultDataWidth = 64;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] rdata;
    logic                        err;
  } mem_resp_t;

  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_bits(input int num_words);
    return $clog2(num_words);
  endfunction

  // Counter must hold StallCycles without wrapping; never narrower than 1 bit.
  function automatic int stall_width(input int stall_cycles);
    return (stall_cycles == 0) ? 1 : $clog2(stall_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_resp_delay.sv
// Fixed-depth, valid-qualified shift register with synchronous clear.
// Clear drops every in-flight entry and zeroes the data path.
module mem_resp_delay #(
  parameter int Depth = 1,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_data  = data_q[Depth-1];

endmodule

// File: rtl/mem_sram_responder.sv
// Single-port SRAM endpoint: accepts valid/ready requests and returns one
// {rdata, err} response per request exactly Latency cycles later.
module mem_sram_responder
  import mem_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int NumWords    = 1024,
  parameter int Latency     = 1,
  parameter int StallCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_we_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic                   resp_err_o,
  output logic                   resp_valid_o
);

  localparam int OffBits  = off_bits(DataWidth);
  localparam int IdxBits  = idx_bits(NumWords);
  localparam int AddrTop  = OffBits + IdxBits;
  localparam int StallW   = stall_width(StallCycles);
  localparam int NumBytes = DataWidth / 8;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } resp_t;

  logic [DataWidth-1:0] mem [NumWords];
  logic [StallW-1:0]    stall_cnt;
  logic [IdxBits-1:0]   index;
  logic                 oor;
  logic                 accept;
  resp_t                resp_in;
  resp_t                resp_out;
  logic                 unused_offset;

  assign index         = req_addr_i[AddrTop-1:OffBits];
  assign unused_offset = ^req_addr_i[OffBits-1:0];

  generate
    if (AddrWidth > AddrTop) begin : g_range
      assign oor = |req_addr_i[AddrWidth-1:AddrTop];
    end else begin : g_no_range
      assign oor = 1'b0;
    end
  endgenerate

  // Ready looks only at the stall counter so valid never feeds back into ready.
  assign req_ready_o = (stall_cnt == '0) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= StallW'(StallCycles);
    end else if (stall_cnt != '0) begin
      stall_cnt <= stall_cnt - StallW'(1);
    end
  end

  // Storage is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !oor) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (req_be_i[b]) mem[index][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_in       = '0;
    resp_in.err   = oor;
    if (accept && !req_we_i && !oor) resp_in.rdata = mem[index];
  end

  mem_resp_delay #(
    .Depth (Latency),
    .Width ($bits(resp_t))
  ) u_delay (
    .clk       (clk_i),
    .clr       (rst_i),
    .in_valid  (accept),
    .in_data   (resp_in),
    .out_valid (resp_valid_o),
    .out_data  (resp_out)
  );

  assign resp_rdata_o = resp_out.rdata;
  assign resp_err_o   = resp_out.err;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed bench for mem_sram_responder: four instances cover the base
// configuration, Latency=3, StallCycles=2 and Latency=4 with mid-flight reset.
module tb_mem_sram_responder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst    [N];
  logic [31:0] addr   [N];
  logic        we     [N];
  logic [7:0]  be     [N];
  logic [63:0] wdata  [N];
  logic        valid  [N];
  logic        ready  [N];
  logic [63:0] rdata  [N];
  logic        err    [N];
  logic        rvalid [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input int d, input logic [31:0] a, input logic w,
                       input logic [7:0] b, input logic [63:0] wd);
    addr[d]  = a;
    we[d]    = w;
    be[d]    = b;
    wdata[d] = wd;
    valid[d] = 1'b1;
    @(posedge clk);
    #1 valid[d] = 1'b0;
    @(negedge clk);
  endtask

  mem_sram_responder #(.AddrWidth(32), .DataWidth(64), .NumWords(16), .Latency(1), .StallCycles(0)) u_base (
    .clk_i(clk), .rst_i(rst[0]), .req_addr_i(addr[0]), .req_we_i(we[0]), .req_be_i(be[0]),
    .req_wdata_i(wdata[0]), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .resp_rdata_o(rdata[0]), .resp_err_o(err[0]), .resp_valid_o(rvalid[0]));

  mem_sram_responder #(.AddrWidth(32), .DataWidth(64), .NumWords(16), .Latency(3), .StallCycles(0)) u_lat3 (
    .clk_i(clk), .rst_i(rst[1]), .req_addr_i(addr[1]), .req_we_i(we[1]), .req_be_i(be[1]),
    .req_wdata_i(wdata[1]), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .resp_rdata_o(rdata[1]), .resp_err_o(err[1]), .resp_valid_o(rvalid[1]));

  mem_sram_responder #(.AddrWidth(32), .DataWidth(64), .NumWords(16), .Latency(1), .StallCycles(2)) u_stall (
    .clk_i(clk), .rst_i(rst[2]), .req_addr_i(addr[2]), .req_we_i(we[2]), .req_be_i(be[2]),
    .req_wdata_i(wdata[2]), .req_valid_i(valid[2]), .req_ready_o(ready[2]),
    .resp_rdata_o(rdata[2]), .resp_err_o(err[2]), .resp_valid_o(rvalid[2]));

  mem_sram_responder #(.AddrWidth(32), .DataWidth(64), .NumWords(16), .Latency(4), .StallCycles(0)) u_lat4 (
    .clk_i(clk), .rst_i(rst[3]), .req_addr_i(addr[3]), .req_we_i(we[3]), .req_be_i(be[3]),
    .req_wdata_i(wdata[3]), .req_valid_i(valid[3]), .req_ready_o(ready[3]),
    .resp_rdata_o(rdata[3]), .resp_err_o(err[3]), .resp_valid_o(rvalid[3]));

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] v0, v1, v2, v4;
    int rp [6];
    int vp [6];
    int pulses;

    v0 = 64'h0000_1111_2222_3333;
    v1 = 64'h4444_5555_6666_7777;
    v2 = 64'h8888_9999_AAAA_BBBB;
    v4 = 64'hCAFE_F00D_1234_5678;
    rp = '{1, 0, 0, 1, 0, 0};
    vp = '{0, 1, 0, 0, 1, 0};

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; addr[d] = '0; we[d] = 1'b0; be[d] = '0; wdata[d] = '0; valid[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready[0], 0);
    check_eq("rst_rvalid", rvalid[0], 0);
    check_eq("rst_rdata", rdata[0], 0);
    check_eq("rst_err", err[0], 0);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;
    #1 check_eq("post_rst_ready", ready[0], 1);
    @(negedge clk);

    // Base configuration, Latency=1
    issue(0, 32'h00, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    check_eq("wr_resp_valid", rvalid[0], 1);
    check_eq("wr_resp_rdata", rdata[0], 0);
    check_eq("wr_resp_err", err[0], 0);
    issue(0, 32'h08, 1'b1, 8'hFF, 64'h1122_3344_5566_7788);
    issue(0, 32'h08, 1'b0, 8'h00, 64'h0);
    check_eq("rd_full_valid", rvalid[0], 1);
    check_eq("rd_full_rdata", rdata[0], 64'h1122_3344_5566_7788);
    check_eq("rd_full_err", err[0], 0);
    issue(0, 32'h08, 1'b1, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
    issue(0, 32'h08, 0, 8'h00, 64'h0);
    check_eq("rd_partial", rdata[0], 64'h1122_3344_AAAA_AAAA);
    issue(0, 32'h08, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("be0_resp_valid", rvalid[0], 1);
    issue(0, 32'h0C, 1'b0, 8'h00, 64'h0);
    check_eq("rd_offset_ignored", rdata[0], 64'h1122_3344_AAAA_AAAA);
    @(negedge clk);
    check_eq("idle_rvalid", rvalid[0], 0);
    issue(0, 32'h80, 1'b0, 8'h00, 64'h0);
    check_eq("oor_valid", rvalid[0], 1);
    check_eq("oor_err", err[0], 1);
    check_eq("oor_rdata", rdata[0], 0);
    issue(0, 32'h00, 1'b0, 8'h00, 64'h0);
    check_eq("after_oor_err", err[0], 0);
    check_eq("after_oor_rdata", rdata[0], 64'h0123_4567_89AB_CDEF);
    issue(0, 32'h88, 1'b1, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    check_eq("oor_wr_err", err[0], 1);
    issue(0, 32'h08, 1'b0, 8'h00, 64'h0);
    check_eq("oor_wr_no_alias", rdata[0], 64'h1122_3344_AAAA_AAAA);

    // Latency=3, back-to-back reads
    issue(1, 32'h00, 1'b1, 8'hFF, v0);
    issue(1, 32'h08, 1'b1, 8'hFF, v1);
    issue(1, 32'h10, 1'b1, 8'hFF, v2);
    repeat (4) @(negedge clk);
    issue(1, 32'h00, 1'b0, 8'h00, 64'h0);
    issue(1, 32'h08, 1'b0, 8'h00, 64'h0);
    check_eq("lat3_not_early", rvalid[1], 0);
    issue(1, 32'h10, 1'b0, 8'h00, 64'h0);
    check_eq("lat3_r0_valid", rvalid[1], 1);
    check_eq("lat3_r0_rdata", rdata[1], v0);
    @(negedge clk);
    check_eq("lat3_r1_valid", rvalid[1], 1);
    check_eq("lat3_r1_rdata", rdata[1], v1);
    @(negedge clk);
    check_eq("lat3_r2_valid", rvalid[1], 1);
    check_eq("lat3_r2_rdata", rdata[1], v2);
    @(negedge clk);
    check_eq("lat3_end", rvalid[1], 0);

    // StallCycles=2 with valid held high
    addr[2] = 32'h00; we[2] = 1'b1; be[2] = 8'h00; wdata[2] = '0; valid[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("stall_ready%0d", i), ready[2], 64'(rp[i]));
      check_eq($sformatf("stall_rvalid%0d", i), rvalid[2], 64'(vp[i]));
      @(negedge clk);
    end
    valid[2] = 1'b0;

    // Latency=4 with a reset while a read is in flight
    issue(3, 32'h18, 1'b1, 8'hFF, v4);
    repeat (5) @(negedge clk);
    issue(3, 32'h18, 1'b0, 8'h00, 64'h0);
    @(negedge clk);
    rst[3] = 1'b1;
    #1 check_eq("lat4_rst_ready", ready[3], 0);
    @(negedge clk);
    rst[3] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid[3]) pulses++;
      @(negedge clk);
    end
    check_eq("lat4_flushed", 64'(pulses), 0);
    issue(3, 32'h18, 1'b0, 8'h00, 64'h0);
    repeat (2) @(negedge clk);
    check_eq("lat4_not_early", rvalid[3], 0);
    @(negedge clk);
    check_eq("lat4_valid", rvalid[3], 1);
    check_eq("lat4_persist", rdata[3], v4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
